// File: rtl/hlsm_cond_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hlsm_cond_mul_seq_pkg
// Brief   : Shared state encoding, legal parameter ranges and a range-check
//           helper for the conditional multiply sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hlsm_cond_mul_seq_pkg;

  // 3-bit encoding leaves codes 6 and 7 unused; the FSM maps them to IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_MUL  = 3'd2,
    S_SEL  = 3'd3,
    S_FIT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam int c_DATA_W_MIN  = 4;
  localparam int c_DATA_W_MAX  = 64;
  localparam int c_MUL_LAT_MIN = 1;
  localparam int c_MUL_LAT_MAX = 4;

  // Wide enough to hold MUL_LAT-1 for the largest legal latency.
  localparam int c_CNT_W = $clog2(c_MUL_LAT_MAX);

  function automatic bit params_legal(input int dw, input int lat);
    return (dw >= c_DATA_W_MIN) && (dw <= c_DATA_W_MAX) &&
           (lat >= c_MUL_LAT_MIN) && (lat <= c_MUL_LAT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hlsm_cond_mul_seq_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module  : hlsm_cond_mul_seq_pipe_mul
// Brief   : LAT-stage signed multiplier. The product of the operands present
//           before edge k appears on o_p after edge k+LAT-1.
// Revision: 1.0 - initial release
// ============================================================================
module hlsm_cond_mul_seq_pipe_mul #(
  parameter int IN_A_W = 33,
  parameter int IN_B_W = 32,
  parameter int LAT    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [IN_A_W-1:0]         i_a,
  input  logic signed [IN_B_W-1:0]         i_b,
  output logic signed [IN_A_W+IN_B_W-1:0]  o_p
);

  localparam int c_PW = IN_A_W + IN_B_W;

  logic signed [c_PW-1:0] r_stage [LAT];

  // Multiply into the first stage, then shift through the remaining stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_a * i_b;
      for (int k = 1; k < LAT; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_p = r_stage[LAT-1];

endmodule
`default_nettype wire

// File: rtl/hlsm_cond_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : hlsm_cond_mul_seq
// Brief   : Start/Done sequencer: d=a+b, e=a-b, then f = t ? d*c : e and
//           g = max(d,e); z/x are f/g fitted to DATA_W (wrap or clamp).
// Revision: 1.0 - initial release
// ============================================================================
module hlsm_cond_mul_seq
  import hlsm_cond_mul_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int SAT     = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic                     t,
  output logic                     Busy,
  output logic                     Done,
  output logic signed [DATA_W-1:0] z,
  output logic signed [DATA_W-1:0] x,
  output logic                     ovf
);

  // Sum/difference carry one guard bit; the product is exact.
  localparam int c_SW = DATA_W + 1;
  localparam int c_PW = c_SW + DATA_W;

  localparam logic signed [c_PW-1:0]    c_ONE      = 1;
  localparam logic signed [c_PW-1:0]    c_MAX      = (c_ONE <<< (DATA_W - 1)) - c_ONE;
  localparam logic signed [c_PW-1:0]    c_MIN      = -(c_ONE <<< (DATA_W - 1));
  localparam logic [c_CNT_W-1:0]        c_CNT_LOAD = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_CNT_W-1:0]        c_CNT_ONE  = 1;

  if (!params_legal(DATA_W, MUL_LAT) || (SAT != 0 && SAT != 1)) begin : g_bad_params
    $error("hlsm_cond_mul_seq: DATA_W, MUL_LAT or SAT out of range");
  end

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_a, r_b, r_c;
  logic                     r_t;
  logic signed [c_SW-1:0]   r_d, r_e;
  logic signed [c_PW-1:0]   r_f;
  logic signed [c_SW-1:0]   r_g;
  logic signed [DATA_W-1:0] r_zf, r_xf;
  logic                     r_of;
  logic [c_CNT_W-1:0]       r_cnt;

  logic signed [c_SW-1:0]   w_d, w_e, w_g;
  logic signed [c_PW-1:0]   w_prod, w_f, w_g_x;
  logic                     w_ovf;

  // Keep the low DATA_W bits, or clamp to the signed range when SAT is set.
  function automatic logic signed [DATA_W-1:0] fit(input logic signed [c_PW-1:0] v);
    logic signed [DATA_W-1:0] w_res;
    w_res = v[DATA_W-1:0];
    if (SAT != 0) begin
      if (v > c_MAX) begin
        w_res = c_MAX[DATA_W-1:0];
      end else if (v < c_MIN) begin
        w_res = c_MIN[DATA_W-1:0];
      end
    end
    return w_res;
  endfunction

  assign w_d   = c_SW'(r_a) + c_SW'(r_b);
  assign w_e   = c_SW'(r_a) - c_SW'(r_b);
  assign w_f   = r_t ? w_prod : c_PW'(r_e);
  assign w_g   = (r_d > r_e) ? r_d : r_e;
  assign w_g_x = c_PW'(r_g);
  assign w_ovf = (r_f > c_MAX) || (r_f < c_MIN) || (w_g_x > c_MAX) || (w_g_x < c_MIN);

  // r_d is stable for the whole MUL stay, so the free-running pipe settles on d*c.
  hlsm_cond_mul_seq_pipe_mul #(
    .IN_A_W (c_SW),
    .IN_B_W (DATA_W),
    .LAT    (MUL_LAT)
  ) u_mul (
    .clk   (Clk),
    .rst_n (Rst),
    .i_a   (r_d),
    .i_b   (r_c),
    .o_p   (w_prod)
  );

  // Sequencer: operand capture, datapath staging and registered Busy/Done/results.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_t     <= 1'b0;
      r_d     <= '0;
      r_e     <= '0;
      r_f     <= '0;
      r_g     <= '0;
      r_zf    <= '0;
      r_xf    <= '0;
      r_of    <= 1'b0;
      r_cnt   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      z       <= '0;
      x       <= '0;
      ovf     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_t     <= t;
            Busy    <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_d <= w_d;
          r_e <= w_e;
          if (r_t) begin
            r_cnt   <= c_CNT_LOAD;
            r_state <= S_MUL;
          end else begin
            r_state <= S_SEL;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_state <= S_SEL;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_SEL: begin
          r_f     <= w_f;
          r_g     <= w_g;
          r_state <= S_FIT;
        end
        // Range check and clamping get their own cycle, off the product path.
        S_FIT: begin
          r_zf    <= fit(r_f);
          r_xf    <= fit(w_g_x);
          r_of    <= w_ovf;
          r_state <= S_FIN;
        end
        S_FIN: begin
          z       <= r_zf;
          x       <= r_xf;
          ovf     <= r_of;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hlsm_cond_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_hlsm_cond_mul_seq
// Brief   : Directed bench: four 32-bit instances (MUL_LAT 1..4, wrap) and two
//           8-bit instances (wrap / clamp) against hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hlsm_cond_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start32, t32, start8, t8;
  logic signed [31:0] a32, b32, c32;
  logic signed [7:0]  a8, b8, c8;

  logic [3:0]         busy32, done32, ovf32;
  logic signed [31:0] z32 [4];
  logic signed [31:0] x32 [4];
  logic [1:0]         busy8, done8, ovf8;
  logic signed [7:0]  z8 [2];
  logic signed [7:0]  x8 [2];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut32
    hlsm_cond_mul_seq #(.DATA_W(32), .MUL_LAT(k + 1), .SAT(0)) u_dut (
      .Clk(clk), .Rst(rst_n), .Start(start32), .a(a32), .b(b32), .c(c32), .t(t32),
      .Busy(busy32[k]), .Done(done32[k]), .z(z32[k]), .x(x32[k]), .ovf(ovf32[k]));
  end

  for (genvar k = 0; k < 2; k++) begin : g_dut8
    hlsm_cond_mul_seq #(.DATA_W(8), .MUL_LAT(2), .SAT(k)) u_dut (
      .Clk(clk), .Rst(rst_n), .Start(start8), .a(a8), .b(b8), .c(c8), .t(t8),
      .Busy(busy8[k]), .Done(done8[k]), .z(z8[k]), .x(x8[k]), .ovf(ovf8[k]));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One op on the 32-bit group; checks latency, single Done, Busy shape, results.
  task automatic run32(input string tag, input logic signed [31:0] ia, ib, ic,
                       input logic it, input logic signed [31:0] ez, ex, input logic eo);
    int lat [4];
    int nd [4];
    int bb [4];
    for (int k = 0; k < 4; k++) begin
      lat[k] = -1; nd[k] = 0; bb[k] = 0;
    end
    @(negedge clk);
    a32 = ia; b32 = ib; c32 = ic; t32 = it; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (done32[k] === 1'b1) begin
          nd[k]++;
          if (lat[k] < 0) lat[k] = n;
        end
        if ((lat[k] < 0) !== busy32[k]) bb[k]++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_lat%0d", tag, k + 1), lat[k], it ? 5 + k : 4);
      chk($sformatf("%s_ndone%0d", tag, k + 1), nd[k], 1);
      chk($sformatf("%s_busy%0d", tag, k + 1), bb[k], 0);
      chk($sformatf("%s_z%0d", tag, k + 1), z32[k], ez);
      chk($sformatf("%s_x%0d", tag, k + 1), x32[k], ex);
      chk($sformatf("%s_ovf%0d", tag, k + 1), ovf32[k], eo);
    end
  endtask

  // One op on the 8-bit pair: index 0 wraps, index 1 clamps.
  task automatic run8(input string tag, input logic signed [7:0] ia, ib, ic, input logic it,
                      input logic signed [7:0] ezw, exw, ezs, exs, input logic eo);
    int lat [2];
    logic signed [7:0] ez [2];
    logic signed [7:0] ex [2];
    ez[0] = ezw; ex[0] = exw; ez[1] = ezs; ex[1] = exs;
    lat[0] = -1; lat[1] = -1;
    @(negedge clk);
    a8 = ia; b8 = ib; c8 = ic; t8 = it; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (done8[k] === 1'b1 && lat[k] < 0) lat[k] = n;
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_lat_s%0d", tag, k), lat[k], it ? 6 : 4);
      chk($sformatf("%s_z_s%0d", tag, k), z8[k], ez[k]);
      chk($sformatf("%s_x_s%0d", tag, k), x8[k], ex[k]);
      chk($sformatf("%s_ovf_s%0d", tag, k), ovf8[k], eo);
    end
  endtask

  initial begin
    int d1 [4];
    int d2 [4];
    int nd;
    int nb;
    rst_n = 1'b0;
    start32 = 1'b0; t32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    start8 = 1'b0;  t8 = 1'b0;  a8 = '0;  b8 = '0;  c8 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", {busy32, busy8}, 6'b0);
    chk("rst_done", {done32, done8}, 6'b0);
    chk("rst_ovf", {ovf32, ovf8}, 6'b0);
    chk("rst_z", z32[1], 32'sd0);
    chk("rst_x", x32[3], 32'sd0);
    chk("rst_z8", z8[1], 8'sd0);
    rst_n = 1'b1;

    // 32-bit wrap: add/sub path, multiply path, signed extremes
    run32("sub",   32'sd5,  32'sd3, 32'sd4,  1'b0, 32'sd2,   32'sd8,  1'b0);
    run32("mul",   32'sd5,  32'sd3, -32'sd4, 1'b1, -32'sd32, 32'sd8,  1'b0);
    run32("neg",  -32'sd9, -32'sd6, -32'sd3, 1'b1, 32'sd45,  -32'sd3, 1'b0);
    run32("mulwr", 32'h7FFF_FFFF, 32'sd1, 32'sd2, 1'b1, 32'sd0, 32'h8000_0000, 1'b1);
    run32("subwr", 32'h8000_0000, 32'sd1, 32'sd0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1);

    // 8-bit wrap vs clamp
    run8("p8",  8'sd100,  8'sd27,  8'sd2,  1'b1, -8'sd2, 8'sd127, 8'sd127,  8'sd127, 1'b1);
    run8("g8",  8'sd100,  8'sd100, 8'sd1,  1'b0, 8'sd0,  -8'sd56, 8'sd0,    8'sd127, 1'b1);
    run8("n8",  -8'sd100, -8'sd100, 8'sd1, 1'b1, 8'sd56, 8'sd0,   -8'sd128, 8'sd0,   1'b1);
    run8("ok8", 8'sd3,    -8'sd4,  -8'sd5, 1'b1, 8'sd5,  8'sd7,   8'sd5,    8'sd7,   1'b0);

    // Start held high: operands and t disturbed while busy must not matter
    for (int k = 0; k < 4; k++) begin
      d1[k] = -1; d2[k] = -1;
    end
    @(negedge clk);
    a32 = 32'sd5; b32 = 32'sd3; c32 = 32'sd4; t32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'sd1000; b32 = -32'sd77; c32 = 32'sd9; t32 = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (done32[k] === 1'b1) begin
          if (d1[k] < 0) d1[k] = n;
          else if (d2[k] < 0) d2[k] = n;
        end
      end
      if (n == 4) begin
        chk("bb_z1", z32[1], 32'sd2);
        chk("bb_x1", x32[1], 32'sd8);
        a32 = -32'sd7; b32 = 32'sd10; c32 = 32'sd0; t32 = 1'b0;
      end
      if (n == 5) begin
        a32 = 32'sd999; b32 = 32'sd1; c32 = 32'sd0; t32 = 1'b1;
      end
      if (n == 9) start32 = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bb_first%0d", k + 1), d1[k], 4);
      chk($sformatf("bb_second%0d", k + 1), d2[k], 9);
      chk($sformatf("bb_z2_%0d", k + 1), z32[k], -32'sd17);
      chk($sformatf("bb_x2_%0d", k + 1), x32[k], 32'sd3);
    end

    // Reset in the middle of a multiply: immediate clear, no late Done
    @(negedge clk);
    a32 = 32'sd5; b32 = 32'sd3; c32 = -32'sd4; t32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy32, 4'b0);
    chk("ar_done", done32, 4'b0);
    chk("ar_z", z32[3], 32'sd0);
    chk("ar_x", x32[1], 32'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done32 !== 4'b0) nd++;
      if (busy32 !== 4'b0) nb++;
    end
    chk("ar_nodone", nd, 0);
    chk("ar_nobusy", nb, 0);
    run32("post", 32'sd5, 32'sd3, 32'sd4, 1'b0, 32'sd2, 32'sd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
